crd_lane_checker: RTL and testbench

//  Multi-lane 8b/10b running-disparity (RD) checker for the PCIe receive path.

---
 rtl/crd_lane_checker.sv | 130 +++++++++++++
 tb/tb_crd_lane_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/crd_lane_checker.sv
// Multi-lane 8b/10b running-disparity checker: per-lane lock FSM, disparity
// violation flags, consecutive-error unlock and saturating error counters.
module crd_lane_checker #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned ERR_CNT_W    = 8,
  parameter int unsigned ERR_LIMIT    = 4,
  parameter int unsigned START_LOCKED = 0,
  parameter int unsigned INIT_RD      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [LANES*10-1:0]        data_in,
  input  logic                       resync,
  input  logic                       cnt_clr,
  output logic                       out_valid,
  output logic [LANES-1:0]           err,
  output logic [LANES-1:0]           crd_bit,
  output logic [LANES-1:0]           locked,
  output logic [LANES*ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
  localparam logic [CW-1:0]        LIMIT_M1 = CW'(ERR_LIMIT - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  typedef enum logic [1:0] {SYM_NEU, SYM_POS, SYM_NEG, SYM_INV} sym_t;

  localparam lock_t RST_STATE = (START_LOCKED != 0) ? LOCKED : UNLOCKED;
  localparam logic  RST_RD    = (INIT_RD != 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_valid <= 1'b0;
    else      out_valid <= in_valid;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [9:0]           sym;
    logic [3:0]           ones;
    sym_t                 cls;
    lock_t                state, state_nxt;
    logic                 rd, rd_nxt;
    logic [CW-1:0]        consec, consec_nxt;
    logic                 err_q, err_nxt;
    logic [ERR_CNT_W-1:0] cnt, cnt_nxt;

    assign sym = data_in[10*k +: 10];

    always_comb begin
      ones = '0;
      for (int unsigned i = 0; i < 10; i++) ones = ones + {3'b000, sym[i]};
    end

    always_comb begin
      case (ones)
        4'd5:    cls = SYM_NEU;
        4'd6:    cls = SYM_POS;
        4'd4:    cls = SYM_NEG;
        default: cls = SYM_INV;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= RST_STATE;
        rd     <= RST_RD;
        consec <= '0;
        err_q  <= 1'b0;
        cnt    <= '0;
      end else begin
        state  <= state_nxt;
        rd     <= rd_nxt;
        consec <= consec_nxt;
        err_q  <= err_nxt;
        cnt    <= cnt_nxt;
      end
    end

    // resync overrides checking; idle cycles leave lock, RD and streak untouched
    always_comb begin
      state_nxt  = state;
      rd_nxt     = rd;
      consec_nxt = consec;
      err_nxt    = 1'b0;
      if (resync) begin
        state_nxt  = UNLOCKED;
        consec_nxt = '0;
      end else if (in_valid) begin
        if (state == UNLOCKED) begin
          case (cls)
            SYM_POS: begin state_nxt = LOCKED; rd_nxt = 1'b1; end
            SYM_NEG: begin state_nxt = LOCKED; rd_nxt = 1'b0; end
            SYM_INV: err_nxt = 1'b1;
            default: ;
          endcase
        end else begin
          case (cls)
            SYM_NEU: ;
            SYM_POS: if (rd) err_nxt = 1'b1; else rd_nxt = 1'b1;
            SYM_NEG: if (!rd) err_nxt = 1'b1; else rd_nxt = 1'b0;
            default: err_nxt = 1'b1;
          endcase
          if (err_nxt) begin
            if (consec == LIMIT_M1) begin
              state_nxt  = UNLOCKED;
              consec_nxt = '0;
            end else begin
              consec_nxt = consec + 1'b1;
            end
          end else begin
            consec_nxt = '0;
          end
        end
      end
    end

    always_comb begin
      cnt_nxt = cnt;
      if (cnt_clr)                       cnt_nxt = '0;
      else if (err_nxt && cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
    end

    assign err[k]                           = err_q;
    assign crd_bit[k]                       = rd;
    assign locked[k]                        = (state == LOCKED);
    assign err_cnt[k*ERR_CNT_W +: ERR_CNT_W] = cnt;
  end

endmodule

// File: tb/tb_crd_lane_checker.sv
// Randomized and directed bench for crd_lane_checker against a disparity-rule
// model; LANES=4, ERR_CNT_W=4, ERR_LIMIT=3.
module tb_crd_lane_checker;

  localparam int LANES = 4;
  localparam int CW    = 4;
  localparam int LIM   = 3;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [9:0] S_POS = 10'b1111110000;
  localparam logic [9:0] S_NEG = 10'b1111000000;
  localparam logic [9:0] S_NEU = 10'b1111100000;
  localparam logic [9:0] S_INV = 10'b1111111100;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic [LANES*10-1:0]   data_in = '0;
  logic                  resync = 1'b0;
  logic                  cnt_clr = 1'b0;
  logic                  out_valid;
  logic [LANES-1:0]      err, crd_bit, locked;
  logic [LANES*CW-1:0]   err_cnt;

  crd_lane_checker #(
    .LANES(LANES), .ERR_CNT_W(CW), .ERR_LIMIT(LIM), .START_LOCKED(0), .INIT_RD(0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .resync(resync), .cnt_clr(cnt_clr), .out_valid(out_valid), .err(err),
    .crd_bit(crd_bit), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the lane's disparity d = ones - 5 must alternate sign
  int m_vld;
  int m_lk[LANES], m_rd[LANES], m_cs[LANES], m_cnt[LANES], m_err[LANES];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld = 0;
      for (int k = 0; k < LANES; k++) begin
        m_lk[k] = 0; m_rd[k] = 0; m_cs[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      end
    end else begin
      m_vld = in_valid;
      for (int k = 0; k < LANES; k++) begin
        logic [9:0] s;
        int d;
        int e;
        s = data_in[10*k +: 10];
        d = $countones(s) - 5;
        e = 0;
        if (resync) begin
          m_lk[k] = 0;
          m_cs[k] = 0;
        end else if (in_valid) begin
          if (m_lk[k] == 0) begin
            if (d == 1 || d == -1) begin
              m_lk[k] = 1;
              m_rd[k] = (d == 1);
            end else if (d != 0) e = 1;
          end else begin
            if (d > 1 || d < -1 || (d == 1 && m_rd[k] == 1) || (d == -1 && m_rd[k] == 0)) begin
              e = 1;
              m_cs[k]++;
              if (m_cs[k] == LIM) begin
                m_lk[k] = 0;
                m_cs[k] = 0;
              end
            end else begin
              if (d != 0) m_rd[k] = (d == 1);
              m_cs[k] = 0;
            end
          end
        end
        m_err[k] = e;
        if (cnt_clr) m_cnt[k] = 0;
        else if (e == 1 && m_cnt[k] < CMAX) m_cnt[k]++;
      end
    end
  end

  always @(negedge clk) begin
    int e_err, e_crd, e_lk, e_cnt;
    e_err = 0; e_crd = 0; e_lk = 0; e_cnt = 0;
    for (int k = 0; k < LANES; k++) begin
      e_err |= m_err[k] << k;
      e_crd |= m_rd[k] << k;
      e_lk  |= m_lk[k] << k;
      e_cnt |= m_cnt[k] << (k * CW);
    end
    chk("out_valid", int'(out_valid), m_vld);
    chk("err",       int'(err),       e_err);
    chk("crd_bit",   int'(crd_bit),   e_crd);
    chk("locked",    int'(locked),    e_lk);
    chk("err_cnt",   int'(err_cnt),   e_cnt);
  end

  task automatic step(input logic [LANES*10-1:0] d, input logic iv,
                      input logic rs, input logic cc);
    data_in  = d;
    in_valid = iv;
    resync   = rs;
    cnt_clr  = cc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] rnd_sym();
    int r, c;
    logic [9:0] s;
    r = int'($urandom_range(0, 11));
    if (r < 3)      c = 5;
    else if (r < 6) c = 6;
    else if (r < 9) c = 4;
    else            c = int'($urandom_range(0, 10));
    s = '0;
    while ($countones(s) != c) s[$urandom_range(0, 9)] = 1'b1;
    return s;
  endfunction

  initial begin
    logic [LANES*10-1:0] d;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err",       int'(err),       0);
    chk("rst_locked",    int'(locked),    0);
    chk("rst_crd",       int'(crd_bit),   0);
    chk("rst_err_cnt",   int'(err_cnt),   0);
    rst = 1'b1;
    step('0, 1'b0, 1'b0, 1'b0);

    step({S_NEU, S_NEU, S_NEU, S_POS}, 1'b1, 1'b0, 1'b0);
    chk("lock_l0",     int'(locked[0]),   1);
    chk("lock_crd_a",  int'(crd_bit[0]),  1);
    chk("lock_others", int'(locked[3:1]), 0);
    step({S_NEU, S_NEU, S_NEU, S_NEG}, 1'b1, 1'b0, 1'b0);
    chk("lock_crd_b",  int'(crd_bit[0]),  0);
    chk("lock_err_b",  int'(err),         0);
    step({S_NEU, S_NEU, S_NEU, S_POS}, 1'b1, 1'b0, 1'b0);
    chk("lock_crd_c",  int'(crd_bit[0]),  1);

    step({S_NEU, S_NEU, S_NEU, S_POS}, 1'b1, 1'b0, 1'b0);
    chk("viol_err0",   int'(err[0]),        1);
    chk("viol_crd0",   int'(crd_bit[0]),    1);
    chk("viol_cnt0",   int'(err_cnt[3:0]),  1);
    chk("viol_err1",   int'(err[1]),        0);

    step({S_NEU, S_POS, S_NEU, S_NEU}, 1'b1, 1'b0, 1'b0);
    chk("l2_lock",     int'(locked[2]),     1);
    for (int i = 0; i < 3; i++) begin
      step({S_NEU, S_INV, S_NEU, S_NEU}, 1'b1, 1'b0, 1'b0);
      chk("limit_err2",  int'(err[2]),    1);
      chk("limit_lock2", int'(locked[2]), (i < 2) ? 1 : 0);
    end
    chk("limit_cnt2",  int'(err_cnt[11:8]), 3);

    for (int i = 0; i < 20; i++) step({S_INV, S_NEU, S_NEU, S_NEU}, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt3",    int'(err_cnt[15:12]), 15);
    step({S_INV, S_NEU, S_NEU, S_NEU}, 1'b1, 1'b0, 1'b1);
    chk("clr_err3",    int'(err[3]),         1);
    chk("clr_cnt3",    int'(err_cnt[15:12]), 0);
    chk("clr_cnt2",    int'(err_cnt[11:8]),  0);

    step({S_INV, S_INV, S_INV, S_INV}, 1'b1, 1'b1, 1'b0);
    chk("rsy_valid",   int'(out_valid), 1);
    chk("rsy_err",     int'(err),       0);
    chk("rsy_locked",  int'(locked),    0);
    chk("rsy_crd0",    int'(crd_bit[0]), 1);

    step({S_INV, S_INV, S_INV, S_POS}, 1'b1, 1'b0, 1'b0);
    step({S_INV, S_INV, S_INV, S_POS}, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_err",   int'(err),       0);
    chk("mid_rst_lock",  int'(locked),    0);
    chk("mid_rst_crd",   int'(crd_bit),   0);
    chk("mid_rst_cnt",   int'(err_cnt),   0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < LANES; k++) d[10*k +: 10] = rnd_sym();
      step(d, ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 49) == 0));
    end
    step('0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
